// File: rtl/gpi_axi_master.sv
// gpi_axi_master
//   Bridges a simple one-at-a-time GPI requester onto an AXI3 master port.
//   Each accepted request becomes a single-beat, 32-bit AXI transaction.
//   Completion is reported on a one-cycle resp_valid strobe.
//
// Handshake rules: every valid/ready pair completes when both are high
// on a rising clock edge. Once this block raises a valid, that valid and
// its payload stay constant until the handshake. resp_valid is a strobe.
// It has no backpressure.
//
// Optional feature: define GPI_AXI_MASTER_ERR_EN to report a nonzero
// rresp/bresp on resp_err. Without it, resp_err is tied to 0.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_*             GPI request (valid/ready, write, addr, wdata, wstrb)
//   resp_*            completion strobe, read data (held), error
//   axi_ar*/axi_r*    AXI3 read address / read data channels
//   axi_aw*/axi_w*    AXI3 write address / write data channels
//   axi_b*            AXI3 write response channel
//   dbg_state         current FSM state (state_t encoding)

module gpi_axi_master #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  // GPI request / response
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // AXI read address
  output logic [3:0]  axi_arid,
  output logic [31:0] axi_araddr,
  output logic [7:0]  axi_arlen,
  output logic [2:0]  axi_arsize,
  output logic [1:0]  axi_arburst,
  output logic [1:0]  axi_arlock,
  output logic [3:0]  axi_arcache,
  output logic [2:0]  axi_arprot,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  // AXI read data
  input  logic [3:0]  axi_rid,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rlast,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  // AXI write address
  output logic [3:0]  axi_awid,
  output logic [31:0] axi_awaddr,
  output logic [7:0]  axi_awlen,
  output logic [2:0]  axi_awsize,
  output logic [1:0]  axi_awburst,
  output logic [1:0]  axi_awlock,
  output logic [3:0]  axi_awcache,
  output logic [2:0]  axi_awprot,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  // AXI write data
  output logic [3:0]  axi_wid,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wlast,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  // AXI write response
  input  logic [3:0]  axi_bid,
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  // debug
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WRITE = 3'd3,
    WRESP = 3'd4
  } state_t;

  state_t      state, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_pend;    // write address not yet handshaken
  logic        w_pend;     // write data not yet handshaken
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;

  logic accept;
  logic aw_hs, w_hs, r_hs, b_hs;

  assign accept = req_valid && (state == IDLE);
  assign aw_hs  = axi_awvalid && axi_awready;
  assign w_hs   = axi_wvalid && axi_wready;
  assign r_hs   = axi_rvalid && axi_rready;
  assign b_hs   = axi_bvalid && axi_bready;

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (accept) state_d = req_write ? WRITE : RADDR;
      RADDR: if (axi_arvalid && axi_arready) state_d = RDATA;
      RDATA: if (r_hs) state_d = IDLE;
      // Leave WRITE when each channel is either already done
      // or handshaking in this cycle.
      WRITE: if ((!aw_pend || aw_hs) && (!w_pend || w_hs)) state_d = WRESP;
      WRESP: if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Request latch and per-channel pending flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
      aw_pend <= req_write;
      w_pend  <= req_write;
    end else begin
      if (aw_hs) aw_pend <= 1'b0;
      if (w_hs)  w_pend  <= 1'b0;
    end
  end

  // Completion strobe and held read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= r_hs || b_hs;
      if (r_hs) resp_rdata_q <= axi_rdata;
    end
  end

`ifdef GPI_AXI_MASTER_ERR_EN
  logic resp_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       resp_err_q <= 1'b0;
    else if (r_hs) resp_err_q <= (axi_rresp != 2'b00);
    else if (b_hs) resp_err_q <= (axi_bresp != 2'b00);
  end
  assign resp_err = resp_err_q;
  logic unused_inputs;
  assign unused_inputs = ^{axi_rid, axi_rlast, axi_bid};
`else
  assign resp_err = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{axi_rid, axi_rlast, axi_bid, axi_rresp, axi_bresp};
`endif

  // Outputs are decoded from state and registers only.
  assign req_ready   = (state == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign dbg_state   = state;

  assign axi_arid    = AXI_ID;
  assign axi_araddr  = addr_q;
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = 3'b010;
  assign axi_arburst = 2'b01;
  assign axi_arlock  = 2'b00;
  assign axi_arcache = 4'b0000;
  assign axi_arprot  = 3'b000;
  assign axi_arvalid = (state == RADDR);
  assign axi_rready  = (state == RDATA);

  assign axi_awid    = AXI_ID;
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = 3'b010;
  assign axi_awburst = 2'b01;
  assign axi_awlock  = 2'b00;
  assign axi_awcache = 4'b0000;
  assign axi_awprot  = 3'b000;
  assign axi_awvalid = (state == WRITE) && aw_pend;

  assign axi_wid     = AXI_ID;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = (state == WRITE) && w_pend;
  assign axi_wlast   = axi_wvalid;

  assign axi_bready  = (state == WRESP);

endmodule

// File: tb/tb_gpi_axi_master.sv
// tb_gpi_axi_master
//   Directed bench for gpi_axi_master. Inputs change 1 time unit after
//   the rising edge. Outputs are checked on the falling edge.
//   Cycle names (T0 = accept cycle) follow the read/write timing of the block.

module tb_gpi_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  axi_arid, axi_awid, axi_wid, axi_rid, axi_bid;
  logic [31:0] axi_araddr, axi_awaddr, axi_wdata, axi_rdata;
  logic [7:0]  axi_arlen, axi_awlen;
  logic [2:0]  axi_arsize, axi_awsize, axi_arprot, axi_awprot;
  logic [1:0]  axi_arburst, axi_awburst, axi_arlock, axi_awlock;
  logic [3:0]  axi_arcache, axi_awcache, axi_wstrb;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast;
  logic [1:0]  axi_rresp, axi_bresp;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast;
  logic        axi_bvalid, axi_bready;
  logic [2:0]  dbg_state;

  int checks = 0;
  int passes = 0;

`ifdef GPI_AXI_MASTER_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  gpi_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
    .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
    .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wid(axi_wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic inputs_idle();
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = '0;
    axi_rid = '0; axi_rlast = 0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = '0; axi_bid = '0;
  endtask

  task automatic present_req(input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1;
    inputs_idle();
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, axi_arvalid, axi_rready, axi_awvalid,
         axi_wvalid, axi_bready} !== 8'b1000_0000)
      $display("FAIL reset_ctrl: got %b want 10000000",
               {req_ready, resp_valid, resp_err, axi_arvalid, axi_rready,
                axi_awvalid, axi_wvalid, axi_bready});
    else passes++;
    checks++;
    if ({axi_araddr, axi_awaddr, axi_wdata, resp_rdata} !== 128'd0)
      $display("FAIL reset_data: got %h want 0",
               {axi_araddr, axi_awaddr, axi_wdata, resp_rdata});
    else passes++;
    step();
    rst = 0;
    step();
  endtask

  task automatic test_read();
    present_req(0, 32'h1000_0004, 32'h0, 4'h0);          // T0
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL rd_t0_ready: got %b want 1", req_ready);
    else passes++;
    step(); inputs_idle(); axi_arready = 1;               // T1
    @(negedge clk);
    checks++;
    if ({axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arid, req_ready}
        !== {1'b1, 32'h1000_0004, 8'd0, 3'd2, 2'b01, 4'h0, 1'b0})
      $display("FAIL rd_t1_ar: got v=%b a=%h len=%h size=%h burst=%b id=%h rdy=%b want 1 10000004 00 2 01 0 0",
               axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arid, req_ready);
    else passes++;
    step(); inputs_idle();                                // T2
    axi_rvalid = 1; axi_rdata = 32'hDEAD_BEEF; axi_rlast = 1;
    @(negedge clk);
    checks++;
    if ({axi_rready, axi_arvalid, resp_valid} !== 3'b100)
      $display("FAIL rd_t2_r: got %b want 100", {axi_rready, axi_arvalid, resp_valid});
    else passes++;
    step(); inputs_idle();                                // T3
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, req_ready, axi_rready, resp_rdata} !== {4'b1010, 32'hDEAD_BEEF})
      $display("FAIL rd_t3_resp: got v=%b e=%b rdy=%b rr=%b d=%h want 1 0 1 0 deadbeef",
               resp_valid, resp_err, req_ready, axi_rready, resp_rdata);
    else passes++;
    step();                                               // T4
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_rdata} !== {1'b0, 32'hDEAD_BEEF})
      $display("FAIL rd_t4_hold: got v=%b d=%h want 0 deadbeef", resp_valid, resp_rdata);
    else passes++;
  endtask

  task automatic test_write_w_first();
    present_req(1, 32'h2000_0000, 32'h1234_5678, 4'b0011);   // T0
    step(); inputs_idle(); axi_wready = 1;                   // T1
    @(negedge clk);
    checks++;
    if ({axi_awvalid, axi_wvalid, axi_wlast, axi_awaddr, axi_wdata, axi_wstrb,
         axi_awsize, axi_awlen, axi_wid}
        !== {3'b111, 32'h2000_0000, 32'h1234_5678, 4'b0011, 3'd2, 8'd0, 4'h0})
      $display("FAIL wr_t1: got aw=%b w=%b l=%b a=%h d=%h s=%b sz=%h len=%h id=%h want 1 1 1 20000000 12345678 0011 2 00 0",
               axi_awvalid, axi_wvalid, axi_wlast, axi_awaddr, axi_wdata, axi_wstrb,
               axi_awsize, axi_awlen, axi_wid);
    else passes++;
    for (int c = 2; c <= 4; c++) begin                       // T2..T4: aw waits
      step(); inputs_idle();
      if (c == 4) axi_awready = 1;
      @(negedge clk);
      checks++;
      if ({axi_awvalid, axi_wvalid, axi_wlast, axi_bready, resp_valid, axi_awaddr}
          !== {5'b10000, 32'h2000_0000})
        $display("FAIL wr_t%0d_aw_hold: got aw=%b w=%b l=%b b=%b rv=%b a=%h want 1 0 0 0 0 20000000",
                 c, axi_awvalid, axi_wvalid, axi_wlast, axi_bready, resp_valid, axi_awaddr);
      else passes++;
    end
    step(); inputs_idle(); axi_bvalid = 1;                   // T5
    @(negedge clk);
    checks++;
    if ({axi_awvalid, axi_wvalid, axi_bready, resp_valid} !== 4'b0010)
      $display("FAIL wr_t5_b: got %b want 0010",
               {axi_awvalid, axi_wvalid, axi_bready, resp_valid});
    else passes++;
    step(); inputs_idle();                                   // T6
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, req_ready, axi_bready} !== 4'b1010)
      $display("FAIL wr_t6_resp: got %b want 1010",
               {resp_valid, resp_err, req_ready, axi_bready});
    else passes++;
    step();                                                  // T7
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) $display("FAIL wr_t7_single: got %b want 0", resp_valid);
    else passes++;
  endtask

  task automatic test_ar_stall();
    present_req(0, 32'h3000_0008, 32'h0, 4'h0);              // T0
    step();
    present_req(0, 32'h3000_0100, 32'h0, 4'h0);              // competing request
    for (int c = 1; c <= 5; c++) begin                       // arready low T1..T5
      @(negedge clk);
      checks++;
      if ({axi_arvalid, req_ready, axi_araddr} !== {2'b10, 32'h3000_0008})
        $display("FAIL stall_t%0d: got v=%b rdy=%b a=%h want 1 0 30000008",
                 c, axi_arvalid, req_ready, axi_araddr);
      else passes++;
      step();
    end
    inputs_idle(); axi_arready = 1;                          // T6
    @(negedge clk);
    checks++;
    if ({axi_arvalid, axi_araddr} !== {1'b1, 32'h3000_0008})
      $display("FAIL stall_t6: got v=%b a=%h want 1 30000008", axi_arvalid, axi_araddr);
    else passes++;
    step(); inputs_idle(); axi_rvalid = 1; axi_rdata = 32'hA5A5_0001;   // T7
    step(); inputs_idle();                                   // T8
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_rdata} !== {1'b1, 32'hA5A5_0001})
      $display("FAIL stall_resp: got v=%b d=%h want 1 a5a50001", resp_valid, resp_rdata);
    else passes++;
    step();                                                  // T9
    @(negedge clk);
    checks++;
    if ({dbg_state, axi_arvalid, req_ready} !== 5'b000_0_1)
      $display("FAIL stall_not_accepted: got st=%0d arv=%b rdy=%b want 0 0 1",
               dbg_state, axi_arvalid, req_ready);
    else passes++;
  endtask

  task automatic test_back_to_back();
    present_req(0, 32'h4000_0000, 32'h0, 4'h0);              // A T0
    step(); inputs_idle(); axi_arready = 1;                  // A T1
    step(); inputs_idle(); axi_rvalid = 1; axi_rdata = 32'h1111_1111;   // A T2
    step(); inputs_idle();                                   // A T3 = B T0
    present_req(0, 32'h4000_0010, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if ({resp_valid, req_ready, resp_rdata} !== {2'b11, 32'h1111_1111})
      $display("FAIL b2b_t3: got v=%b rdy=%b d=%h want 1 1 11111111",
               resp_valid, req_ready, resp_rdata);
    else passes++;
    step(); inputs_idle(); axi_arready = 1;                  // B T1
    @(negedge clk);
    checks++;
    if ({axi_arvalid, resp_valid, axi_araddr} !== {2'b10, 32'h4000_0010})
      $display("FAIL b2b_ar: got v=%b rv=%b a=%h want 1 0 40000010",
               axi_arvalid, resp_valid, axi_araddr);
    else passes++;
    step(); inputs_idle(); axi_rvalid = 1; axi_rdata = 32'h2222_2222;   // B T2
    step(); inputs_idle();                                   // B T3
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_rdata} !== {1'b1, 32'h2222_2222})
      $display("FAIL b2b_resp: got v=%b d=%h want 1 22222222", resp_valid, resp_rdata);
    else passes++;
    step();
  endtask

  task automatic test_write_err();
    present_req(1, 32'h5000_0000, 32'hCAFE_F00D, 4'hF);      // T0
    step(); inputs_idle(); axi_awready = 1; axi_wready = 1;  // T1 both at once
    @(negedge clk);
    checks++;
    if ({axi_awvalid, axi_wvalid} !== 2'b11)
      $display("FAIL err_t1: got %b want 11", {axi_awvalid, axi_wvalid});
    else passes++;
    step(); inputs_idle(); axi_bvalid = 1; axi_bresp = 2'b10;   // T2
    @(negedge clk);
    checks++;
    if ({axi_bready, axi_awvalid, axi_wvalid} !== 3'b100)
      $display("FAIL err_t2: got %b want 100", {axi_bready, axi_awvalid, axi_wvalid});
    else passes++;
    step(); inputs_idle();                                   // T3
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err} !== {1'b1, ERR_EXP})
      $display("FAIL err_t3: got v=%b e=%b want 1 %b", resp_valid, resp_err, ERR_EXP);
    else passes++;
    step();
  endtask

  task automatic test_reset_mid();
    present_req(0, 32'h6000_0000, 32'h0, 4'h0);              // T0
    step(); inputs_idle(); axi_arready = 1;                  // T1
    step(); inputs_idle();                                   // T2: RDATA
    @(negedge clk);
    checks++;
    if (axi_rready !== 1'b1) $display("FAIL rstmid_pre: got %b want 1", axi_rready);
    else passes++;
    #1 rst = 1;
    #1;
    checks++;
    if ({axi_rready, axi_arvalid, axi_awvalid, axi_wvalid, axi_bready, resp_valid,
         req_ready, resp_rdata} !== {7'b0000001, 32'h0})
      $display("FAIL rstmid_async: got %b d=%h want 0000001 0",
               {axi_rready, axi_arvalid, axi_awvalid, axi_wvalid, axi_bready,
                resp_valid, req_ready}, resp_rdata);
    else passes++;
    step(); rst = 0;
    step();
    present_req(0, 32'h7000_000C, 32'h0, 4'h0);              // fresh T0
    step(); inputs_idle(); axi_arready = 1;                  // T1
    @(negedge clk);
    checks++;
    if ({axi_arvalid, axi_araddr} !== {1'b1, 32'h7000_000C})
      $display("FAIL rstmid_ar: got v=%b a=%h want 1 7000000c", axi_arvalid, axi_araddr);
    else passes++;
    step(); inputs_idle(); axi_rvalid = 1; axi_rdata = 32'h0BAD_F00D;   // T2
    step(); inputs_idle();                                   // T3
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'h0BAD_F00D})
      $display("FAIL rstmid_resp: got v=%b e=%b d=%h want 1 0 0badf00d",
               resp_valid, resp_err, resp_rdata);
    else passes++;
    step();
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_read();
    test_write_w_first();
    test_ar_stall();
    test_back_to_back();
    test_write_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
